// File: rtl/debounce_edge_detector.sv
// Multi-channel button conditioner: 2-FF sync, counter debounce, selectable
// edge pulse and hold-to-repeat pulse per channel. All outputs registered.
module debounce_edge_detector #(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned DB_CYCLES     = 16,
   parameter int unsigned HOLD_CYCLES   = 64,
   parameter int unsigned REPEAT_CYCLES = 16,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   sig,
   input  logic [2*CHANNELS-1:0] edge_mode,
   input  logic [CHANNELS-1:0]   repeat_en,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   pulse,
   output logic [CHANNELS-1:0]   rpt
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic [CHANNELS-1:0] s1_q, s2_q;
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] pulse_q, pulse_d;
   logic [CHANNELS-1:0] rpt_q, rpt_d;
   // phase_q: 0 while waiting for the first repeat, 1 between later repeats
   logic [CHANNELS-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]    db_cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    db_cnt_d   [CHANNELS];
   logic [CNT_W-1:0]    hold_cnt_q [CHANNELS];
   logic [CNT_W-1:0]    hold_cnt_d [CHANNELS];

   always_comb begin
      level_d = level_q;
      pulse_d = '0;
      rpt_d   = '0;
      phase_d = phase_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         db_cnt_d[i]   = db_cnt_q[i];
         hold_cnt_d[i] = hold_cnt_q[i];

         if (s2_q[i] == level_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            db_cnt_d[i] = '0;
            level_d[i]  = s2_q[i];
            pulse_d[i]  = s2_q[i] ? edge_mode[2*i] : edge_mode[2*i+1];
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
         end

         // A falling toggle on this edge suppresses any repeat due now
         if (!level_q[i] || !level_d[i] || !repeat_en[i]) begin
            hold_cnt_d[i] = '0;
            phase_d[i]    = 1'b0;
         end else if (hold_cnt_q[i] == (phase_q[i] ? RPT_LAST : HOLD_LAST)) begin
            hold_cnt_d[i] = '0;
            phase_d[i]    = 1'b1;
            rpt_d[i]      = 1'b1;
         end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         pulse_q <= '0;
         rpt_q   <= '0;
         phase_q <= '0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            db_cnt_q[i]   <= '0;
            hold_cnt_q[i] <= '0;
         end
      end else begin
         s1_q    <= sig;
         s2_q    <= s1_q;
         level_q <= level_d;
         pulse_q <= pulse_d;
         rpt_q   <= rpt_d;
         phase_q <= phase_d;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            db_cnt_q[i]   <= db_cnt_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
         end
      end
   end

   assign level = level_q;
   assign pulse = pulse_q;
   assign rpt   = rpt_q;

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Randomised + directed bench for debounce_edge_detector against a
// history-window reference model kept in the bench.
module tb_debounce_edge_detector;

   localparam int NCH  = 4;
   localparam int DB   = 4;
   localparam int HOLD = 8;
   localparam int REP  = 3;

   logic             clk;
   logic             rst_n;
   logic [NCH-1:0]   sig;
   logic [2*NCH-1:0] edge_mode;
   logic [NCH-1:0]   repeat_en;
   logic [NCH-1:0]   level, pulse, rpt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pcnt [NCH];
   int rpt_log [$];

   debounce_edge_detector #(
      .CHANNELS(NCH), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sig(sig), .edge_mode(edge_mode),
      .repeat_en(repeat_en), .level(level), .pulse(pulse), .rpt(rpt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: level flips once the last DB synchronised samples all
   // disagree with it; repeats are timed from the edge the hold became valid.
   logic [NCH-1:0] m_s1, m_s2, m_level, m_pulse, m_rpt;
   logic [DB-1:0]  m_hist [NCH];
   int             m_start [NCH];
   int             m_edge;
   logic           nl;
   int             el;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0; m_rpt = '0; m_edge = 0;
         for (int i = 0; i < NCH; i++) begin
            m_hist[i] = '0;
            m_start[i] = 0;
         end
      end else begin
         m_edge++;
         for (int i = 0; i < NCH; i++) begin
            m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
            nl = m_level[i];
            if (m_hist[i] == {DB{~m_level[i]}}) nl = ~m_level[i];
            m_pulse[i] = (nl & ~m_level[i] & edge_mode[2*i]) |
                         (~nl & m_level[i] & edge_mode[2*i+1]);
            if (m_level[i] && nl && repeat_en[i]) begin
               el = m_edge - m_start[i];
               m_rpt[i] = (el >= HOLD) && (((el - HOLD) % REP) == 0);
            end else begin
               m_start[i] = m_edge;
               m_rpt[i] = 1'b0;
            end
            m_level[i] = nl;
         end
         m_s2 = m_s1;
         m_s1 = sig;
      end
   end

   logic chk_on = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NCH; i++) pcnt[i] += int'(pulse[i]);
         if (rpt[3]) rpt_log.push_back(cyc);
         if (chk_on) begin
            chk("model_level", 32'(level), 32'(m_level));
            chk("model_pulse", 32'(pulse), 32'(m_pulse));
            chk("model_rpt",   32'(rpt),   32'(m_rpt));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_level(input int ch, output int l);
      l = -1;
      for (int k = 0; k < 20 && l < 0; k++) begin
         step(1);
         if (level[ch]) l = cyc;
      end
      chk("wait_level", 32'(l >= 0), 32'd1);
   endtask

   int p0, l_edge;

   initial begin
      for (int i = 0; i < NCH; i++) pcnt[i] = 0;
      rst_n = 1'b0; sig = '0; edge_mode = '0; repeat_en = '0;
      step(3);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_pulse", 32'(pulse), 32'd0);
      chk("reset_rpt",   32'(rpt),   32'd0);
      rst_n = 1'b1;
      chk_on = 1'b1;
      step(2);

      // Step on ch0, mode rising
      edge_mode = 8'b0000_0001;
      sig[0] = 1'b1;
      step(5);
      chk("step_e4_level", 32'(level), 32'd0);
      step(1);
      chk("step_e5_level", 32'(level), 32'b0001);
      chk("step_e5_pulse", 32'(pulse), 32'b0001);
      step(1);
      chk("step_e6_pulse", 32'(pulse), 32'd0);
      sig[0] = 1'b0;
      step(10);

      // Glitch rejection and both-edge pulses on ch1
      edge_mode = 8'b0000_1100;
      p0 = pcnt[1];
      sig[1] = 1'b1; step(3); sig[1] = 1'b0; step(10);
      chk("glitch_level", 32'(level[1]), 32'd0);
      chk("glitch_pulses", 32'(pcnt[1] - p0), 32'd0);
      sig[1] = 1'b1; step(4); sig[1] = 1'b0; step(3);
      chk("short_high_level", 32'(level[1]), 32'd1);
      step(10);
      chk("short_low_level", 32'(level[1]), 32'd0);
      chk("both_pulses", 32'(pcnt[1] - p0), 32'd2);

      // ch2 mode falling only
      edge_mode = 8'b0010_0000;
      p0 = pcnt[2];
      sig[2] = 1'b1; step(8); sig[2] = 1'b0; step(8);
      chk("fall_mode_pulses", 32'(pcnt[2] - p0), 32'd1);
      // mode off: level follows, no pulse
      edge_mode = 8'b0000_0000;
      p0 = pcnt[2];
      sig[2] = 1'b1; step(8);
      chk("off_mode_level", 32'(level[2]), 32'd1);
      sig[2] = 1'b0; step(8);
      chk("off_mode_pulses", 32'(pcnt[2] - p0), 32'd0);
      // mode 01 -> 10 mid-debounce: rising toggle sees 10
      edge_mode = 8'b0001_0000;
      p0 = pcnt[2];
      sig[2] = 1'b1; step(3); edge_mode = 8'b0010_0000; step(8);
      chk("mode_change_pulses", 32'(pcnt[2] - p0), 32'd0);
      sig[2] = 1'b0; step(8);
      edge_mode = '0;

      // Hold-to-repeat on ch3; release lands on a repeat edge (fall wins)
      repeat_en[3] = 1'b1;
      sig[3] = 1'b1;
      wait_level(3, l_edge);
      rpt_log.delete();
      step(14);
      sig[3] = 1'b0;
      step(18);
      chk("rpt_count", 32'(rpt_log.size()), 32'd4);
      chk("rpt_0", 32'(rpt_log[0]), 32'(l_edge + 8));
      chk("rpt_1", 32'(rpt_log[1]), 32'(l_edge + 11));
      chk("rpt_2", 32'(rpt_log[2]), 32'(l_edge + 14));
      chk("rpt_3", 32'(rpt_log[3]), 32'(l_edge + 17));
      chk("rpt_release_level", 32'(level[3]), 32'd0);

      // repeat_en dropped and re-raised mid-hold
      sig[3] = 1'b1;
      wait_level(3, l_edge);
      rpt_log.delete();
      step(9); repeat_en[3] = 1'b0;
      step(3); repeat_en[3] = 1'b1;
      step(12);
      chk("reen_count", 32'(rpt_log.size()), 32'd3);
      chk("reen_0", 32'(rpt_log[0]), 32'(l_edge + 8));
      chk("reen_1", 32'(rpt_log[1]), 32'(l_edge + 20));
      chk("reen_2", 32'(rpt_log[2]), 32'(l_edge + 23));
      sig[3] = 1'b0; repeat_en[3] = 1'b0;
      step(10);

      // All channels together, mode both
      edge_mode = 8'hFF;
      sig = 4'hF;
      step(5);
      chk("conc_e4_pulse", 32'(pulse), 32'd0);
      step(1);
      chk("conc_e5_level", 32'(level), 32'hF);
      chk("conc_e5_pulse", 32'(pulse), 32'hF);
      step(1);
      chk("conc_e6_pulse", 32'(pulse), 32'd0);
      sig = '0;
      step(10);

      // Randomised phase against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) sig = NCH'($urandom);
         if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
         if ($urandom_range(0, 15) == 0) repeat_en = NCH'($urandom);
         step(1);
      end
      sig = '0; repeat_en = '0;
      step(12);

      // Asynchronous reset mid-debounce, then re-debounce after release
      edge_mode = 8'b0000_0001;
      sig[1] = 1'b1;
      step(8);
      sig[0] = 1'b1;
      step(4);
      chk_on = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", 32'(level), 32'd0);
      chk("async_rst_pulse", 32'(pulse), 32'd0);
      chk("async_rst_rpt",   32'(rpt),   32'd0);
      step(2);
      rst_n = 1'b1;
      chk_on = 1'b1;
      step(5);
      chk("rel_e5_level", 32'(level), 32'd0);
      step(1);
      chk("rel_e6_level", 32'(level), 32'b0011);
      chk("rel_e6_pulse", 32'(pulse), 32'b0001);
      step(1);
      chk("rel_e7_pulse", 32'(pulse), 32'd0);
      step(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/debounce_edge_detector.md
Name: debounce_edge_detector

Overview:
- Multi-channel input conditioner for the clock's push-buttons and slow control inputs; successor to the single-channel edge detector.
- Per channel: 2-FF synchroniser, counter-based debounce, a selectable edge-pulse mode (rising/falling/both/off), and optional hold-to-repeat pulses for time-setting buttons.
- Sits between the raw button pins and the clock-setting FSM.

Parameters:
- CHANNELS, 4, number of independent input channels.
- DB_CYCLES, 16, consecutive cycles a synchronised input must differ from the current level before the level flips (legal range 1..2^CNT_W-1).
- HOLD_CYCLES, 64, cycles after a debounced rise before the first repeat pulse (legal range 1..2^CNT_W-1).
- REPEAT_CYCLES, 16, cycles between successive repeat pulses (legal range 1..2^CNT_W-1).
- CNT_W, 16, width of each per-channel counter.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous and active-low.
- sig  input  CHANNELS  raw asynchronous inputs; bit i is channel i.
- edge_mode  input  2*CHANNELS  per-channel mode in bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- repeat_en  input  CHANNELS  per-channel enable for hold-to-repeat.
- level  output  CHANNELS  registered debounced level.
- pulse  output  CHANNELS  one-cycle edge pulse, registered.
- rpt  output  CHANNELS  one-cycle repeat pulse, registered.

Behaviour:
- Reset (async assert, sync release): all sync flops, counters, level, pulse and rpt are 0.
- Channels are fully independent; bit i never influences bit j.
- Sync: s1 <= sig, s2 <= s1. Only s2 is used downstream.
- Debounce counter db_cnt:
  - s2 == level: db_cnt <= 0.
  - s2 != level and db_cnt == DB_CYCLES-1: level <= s2, db_cnt <= 0.
  - otherwise: db_cnt increments.
- Latency: sig stable from before edge E0 -> level changes at edge E(DB_CYCLES+1), i.e. DB_CYCLES+2 edges.
- Glitch rejection: any excursion of s2 shorter than DB_CYCLES cycles leaves level unchanged and clears db_cnt on return.
- pulse: registered at the same edge level toggles, high exactly one cycle.
  - Rising toggle asserts pulse if mode is 01 or 11.
  - Falling toggle asserts pulse if mode is 10 or 11.
  - Mode 00: no pulse; level still tracks the input.
- edge_mode is sampled at the toggle edge; mode changes at any other time have no side effects.
- Repeat counter hold_cnt:
  - level == 0 or repeat_en == 0: hold_cnt <= 0, rpt <= 0.
  - If level rises at edge L with repeat_en high throughout, rpt is high for one cycle at edges L+HOLD_CYCLES, L+HOLD_CYCLES+REPEAT_CYCLES, L+HOLD_CYCLES+2*REPEAT_CYCLES, and so on until level falls.
  - rpt is independent of edge_mode.
  - Deasserting repeat_en mid-hold clears hold_cnt. Re-asserting restarts timing: first rpt HOLD_CYCLES edges after the re-enable edge.
- Counters never wrap. hold_cnt stays below max(HOLD_CYCLES, REPEAT_CYCLES), reloading to the repeat phase after each rpt.
- Simultaneous toggles on several channels each produce their own pulse in the same cycle.
- Level fall on the same edge a rpt would fire: the fall wins, rpt = 0.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously). After release, an input held high is re-debounced: level and pulse rise DB_CYCLES+2 edges after release, with pulse if mode is 01 or 11.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: CHANNELS=4, DB_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3.)
- Step: ch0 mode 01, sig[0] 0->1 before edge E0 and held -> level[0]=1 and pulse[0]=1 at E5 only; pulse[0]=0 at E6; other channels stay 0.
- Glitch: sig[1] high for 3 cycles, mode 11 -> level[1], pulse[1] stay 0. A 4-cycle high -> level[1] rises. The 4-cycle low that follows -> level[1] falls, with pulse[1] on both toggles.
- Modes:
  - ch2 press/release, mode 10: pulse only on the falling toggle.
  - Mode 00: level follows, pulse never asserts.
  - Mode changed mid-debounce from 01 to 10: the rising toggle gives no pulse.
- Repeat: ch3 repeat_en=1, held high; level rises at edge L -> rpt[3] at L+8, L+11, L+14.
  - Release -> rpt stops, no stale pulse.
  - repeat_en dropped at L+9 and raised at L+12 -> next rpt at L+20.
- Concurrency: all 4 channels stepped high the same cycle, mode 11 -> all level and pulse bits assert together at E5 (pulse=4'hF for one cycle).
- Reset: rst_n low at E3 of a ch0 debounce -> outputs 0 immediately, with no clock edge. sig[0] held high and rst_n released -> level[0] and pulse[0] rise 6 edges after release.
